// File: rtl/ksa_shuffle_param.sv
// ksa_shuffle_param: RC4 key-scheduling engine driving an external single-port S memory.
// Optional S[i]=i fill, then the 256-step swap loop; key length and read latency are parameters.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; outputs parked at zero
// INIT   | writing S[i]=i, one address per cycle
// RD_I   | address=i held until rd_data is valid, then capture si
// CALC_J | j += si + key[kidx]
// RD_J   | address=j held until rd_data is valid, then capture sj
// WR_I   | S[i] <= sj
// WR_J   | S[j] <= si, advance i and kidx
// DONE   | one-cycle completion pulse
module ksa_shuffle_param #(
    parameter int KEY_BYTES  = 3,
    parameter int MEM_RD_LAT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   do_init,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             rd_data,
    output logic [7:0]             address,
    output logic [7:0]             wr_data,
    output logic                   wr_en,
    output logic                   busy,
    output logic                   done
);
    localparam int            KW       = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0] KIDX_MAX = KW'(KEY_BYTES - 1);
    localparam logic [2:0]    WAIT_TC  = 3'(MEM_RD_LAT);

    if (KEY_BYTES < 1 || KEY_BYTES > 32) begin : g_bad_key_bytes
        $error("ksa_shuffle_param: KEY_BYTES must be in 1..32");
    end
    if (MEM_RD_LAT < 1 || MEM_RD_LAT > 4) begin : g_bad_rd_lat
        $error("ksa_shuffle_param: MEM_RD_LAT must be in 1..4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RD_I,
        S_CALC_J,
        S_RD_J,
        S_WR_I,
        S_WR_J,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    i_q, i_d;
    logic [7:0]    j_q, j_d;
    logic [KW-1:0] kidx_q, kidx_d;
    logic [7:0]    si_q, si_d;
    logic [7:0]    sj_q, sj_d;
    logic [2:0]    wait_q, wait_d;
    logic [7:0]    address_q, address_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          wr_en_q, wr_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Byte 0 of the key sits in the most significant byte of secret_key.
    logic [7:0] key_byte [KEY_BYTES];

    always_comb begin
        for (int k = 0; k < KEY_BYTES; k++) begin
            key_byte[k] = secret_key[8*(KEY_BYTES-k)-1 -: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            i_q       <= 8'h00;
            j_q       <= 8'h00;
            kidx_q    <= '0;
            si_q      <= 8'h00;
            sj_q      <= 8'h00;
            wait_q    <= 3'd0;
            address_q <= 8'h00;
            wr_data_q <= 8'h00;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            kidx_q    <= kidx_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            wait_q    <= wait_d;
            address_q <= address_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        kidx_d    = kidx_q;
        si_d      = si_q;
        sj_d      = sj_q;
        wait_d    = wait_q;
        address_d = 8'h00;
        wr_data_d = 8'h00;
        wr_en_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    i_d     = 8'h00;
                    j_d     = 8'h00;
                    kidx_d  = '0;
                    wait_d  = WAIT_TC;
                    state_d = do_init ? S_INIT : S_RD_I;
                end
            end
            S_INIT: begin
                i_d = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    wait_d  = WAIT_TC;
                    state_d = S_RD_I;
                end
            end
            S_RD_I: begin
                if (wait_q == 3'd0) begin
                    si_d    = rd_data;
                    state_d = S_CALC_J;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            S_CALC_J: begin
                j_d     = j_q + si_q + key_byte[kidx_q];
                wait_d  = WAIT_TC;
                state_d = S_RD_J;
            end
            S_RD_J: begin
                if (wait_q == 3'd0) begin
                    sj_d    = rd_data;
                    state_d = S_WR_I;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            S_WR_I: begin
                state_d = S_WR_J;
            end
            S_WR_J: begin
                i_d    = i_q + 8'd1;
                kidx_d = (kidx_q == KIDX_MAX) ? '0 : kidx_q + KW'(1);
                if (i_q == 8'hFF) begin
                    state_d = S_DONE;
                end else begin
                    wait_d  = WAIT_TC;
                    state_d = S_RD_I;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Memory port is registered, so it is decoded from the state being entered.
        case (state_d)
            S_INIT: begin
                address_d = i_d;
                wr_data_d = i_d;
                wr_en_d   = 1'b1;
            end
            S_RD_I, S_CALC_J: begin
                address_d = i_d;
            end
            S_RD_J: begin
                address_d = j_d;
            end
            S_WR_I: begin
                address_d = i_d;
                wr_data_d = sj_d;
                wr_en_d   = 1'b1;
            end
            S_WR_J: begin
                address_d = j_d;
                wr_data_d = si_d;
                wr_en_d   = 1'b1;
            end
            default: begin
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign address = address_q;
    assign wr_data = wr_data_q;
    assign wr_en   = wr_en_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_ksa_shuffle_param.sv
// Bench for ksa_shuffle_param: three parameter sets against a latency-accurate S memory,
// with per-cycle memory traffic, done timing and final S contents scoreboarded.
`timescale 1ns/1ps
module tb_ksa_shuffle_param;
    typedef struct packed {
        int         cyc;
        logic [7:0] addr;
        logic       we;
        logic [7:0] dat;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      rst_v = '0, start_v = '0, init_v = '0, fill_req = '0, run_act = '0;
    logic [23:0]     key0 = '0;
    logic [7:0]      key1 = '0;
    logic [255:0]    key2 = '0;
    logic [2:0][7:0] rdat_v, addr_v, wdat_v;
    logic [2:0]      wen_v, busy_v, done_v;

    logic [7:0] mem  [3][256];
    logic [7:0] pipe [3][4];
    int         cyc = 0;

    ev_t        evq        [3][$];
    int         exp_done_q [3][$];
    logic [7:0] exp_s_q    [3][$];
    int st_cyc [3], exp_n [3], ev_bad [3], busy_bad [3], done_cnt [3], done_rel [3];
    int d0 [3], eb0 [3], bb0 [3];
    int n_chk = 0, n_pass = 0;

    function automatic int kb_of(input int n);
        case (n)
            0: return 3;
            1: return 1;
            default: return 32;
        endcase
    endfunction

    function automatic int lat_of(input int n);
        case (n)
            0: return 2;
            1: return 1;
            default: return 4;
        endcase
    endfunction

    ksa_shuffle_param #(.KEY_BYTES(3), .MEM_RD_LAT(2)) u_dut0 (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .do_init(init_v[0]),
        .secret_key(key0), .rd_data(rdat_v[0]), .address(addr_v[0]),
        .wr_data(wdat_v[0]), .wr_en(wen_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    ksa_shuffle_param #(.KEY_BYTES(1), .MEM_RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .do_init(init_v[1]),
        .secret_key(key1), .rd_data(rdat_v[1]), .address(addr_v[1]),
        .wr_data(wdat_v[1]), .wr_en(wen_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    ksa_shuffle_param #(.KEY_BYTES(32), .MEM_RD_LAT(4)) u_dut2 (
        .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .do_init(init_v[2]),
        .secret_key(key2), .rd_data(rdat_v[2]), .address(addr_v[2]),
        .wr_data(wdat_v[2]), .wr_en(wen_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    // S memories: read data follows the address presented MEM_RD_LAT cycles earlier.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int n = 0; n < 3; n++) begin
            if (wen_v[n]) mem[n][addr_v[n]] <= wdat_v[n];
            pipe[n][0] <= addr_v[n];
            for (int k = 1; k < 4; k++) pipe[n][k] <= pipe[n][k-1];
            if (fill_req[n]) for (int k = 0; k < 256; k++) mem[n][k] <= 8'(k);
        end
    end

    always_comb begin
        rdat_v = '0;
        for (int n = 0; n < 3; n++) rdat_v[n] = mem[n][pipe[n][lat_of(n) - 1]];
    end

    always @(negedge clk) begin : mon
        int  rel;
        ev_t e;
        for (int n = 0; n < 3; n++) begin
            if (done_v[n]) begin
                done_cnt[n]++;
                done_rel[n] = cyc - st_cyc[n];
            end
            if (run_act[n]) begin
                rel = cyc - st_cyc[n];
                if (rel >= 1) begin
                    if (rel <= exp_n[n] && !busy_v[n]) busy_bad[n]++;
                    if (evq[n].size() > 0 && evq[n][0].cyc == rel) begin
                        e = evq[n].pop_front();
                        if (addr_v[n] !== e.addr || wen_v[n] !== e.we ||
                            (e.we && wdat_v[n] !== e.dat)) ev_bad[n]++;
                    end else if (wen_v[n] !== 1'b0) begin
                        ev_bad[n]++;
                    end
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference KSA: expected per-cycle memory traffic, done cycle and final S.
    task automatic build_run(input int n, input bit init, input logic [255:0] key);
        logic [7:0] s [256];
        logic [7:0] j, si, sj, kb;
        int c, kbn, lat;
        kbn = kb_of(n);
        lat = lat_of(n);
        for (int k = 0; k < 256; k++) s[k] = init ? 8'(k) : mem[n][k];
        c = 1;
        if (init) begin
            for (int k = 0; k < 256; k++) begin
                evq[n].push_back('{c, 8'(k), 1'b1, 8'(k)});
                c++;
            end
        end
        j = 8'h00;
        for (int i = 0; i < 256; i++) begin
            for (int r = 0; r <= lat; r++) evq[n].push_back('{c + r, 8'(i), 1'b0, 8'h00});
            c += lat + 1;
            si = s[i];
            kb = 8'(key >> (8 * (kbn - 1 - (i % kbn))));
            j  = j + si + kb;
            c += 1;
            for (int r = 0; r <= lat; r++) evq[n].push_back('{c + r, j, 1'b0, 8'h00});
            c += lat + 1;
            sj = s[j];
            evq[n].push_back('{c, 8'(i), 1'b1, sj});
            c++;
            evq[n].push_back('{c, j, 1'b1, si});
            c++;
            s[i] = sj;
            s[j] = si;
        end
        exp_done_q[n].push_back(c);
        for (int k = 0; k < 256; k++) exp_s_q[n].push_back(s[k]);
    endtask

    // Called at negedge+1 of an idle cycle; returns at negedge+1 of cycle 1.
    task automatic start_run(input int n, input bit init, input logic [255:0] key);
        build_run(n, init, key);
        exp_n[n] = exp_done_q[n][exp_done_q[n].size() - 1];
        d0[n]  = done_cnt[n];
        eb0[n] = ev_bad[n];
        bb0[n] = busy_bad[n];
        st_cyc[n]  = cyc;
        run_act[n] = 1'b1;
        case (n)
            0: key0 = key[23:0];
            1: key1 = key[7:0];
            default: key2 = key;
        endcase
        init_v[n]  = init;
        start_v[n] = 1'b1;
        @(negedge clk); #1;
        start_v[n] = 1'b0;
    endtask

    task automatic run_ksa(input int n, input bit init, input logic [255:0] key,
                           input int pa, input int pb);
        int exp_c, rel;
        start_run(n, init, key);
        exp_c = exp_done_q[n].pop_front();
        rel = cyc - st_cyc[n];
        while (done_cnt[n] == d0[n] && rel <= exp_c + 50) begin
            start_v[n] = (rel == pa || rel == pb);
            @(negedge clk); #1;
            rel = cyc - st_cyc[n];
        end
        start_v[n] = 1'b0;
        check_eq($sformatf("u%0d.done_seen", n), done_cnt[n] - d0[n], 1);
        check_eq($sformatf("u%0d.done_cycle", n), done_rel[n], exp_c);
        check_eq($sformatf("u%0d.busy_window", n), busy_bad[n] - bb0[n], 0);
        check_eq($sformatf("u%0d.mem_traffic", n), ev_bad[n] - eb0[n], 0);
        check_eq($sformatf("u%0d.traffic_left", n), evq[n].size(), 0);
        for (int k = 0; k < 256; k++)
            check_eq($sformatf("u%0d.S[%0d]", n, k), mem[n][k], exp_s_q[n].pop_front());
        @(negedge clk); #1;
        check_eq($sformatf("u%0d.idle_busy", n), busy_v[n], 0);
        check_eq($sformatf("u%0d.idle_done", n), done_v[n], 0);
        check_eq($sformatf("u%0d.single_done", n), done_cnt[n] - d0[n], 1);
        run_act[n] = 1'b0;
        evq[n].delete();
        exp_s_q[n].delete();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [255:0] key32;
        int rel;
        #1;
        rst_v    = 3'b111;
        fill_req = 3'b111;
        #1;
        for (int n = 0; n < 3; n++) begin
            check_eq($sformatf("u%0d.rst_address", n), addr_v[n], 0);
            check_eq($sformatf("u%0d.rst_wr_data", n), wdat_v[n], 0);
            check_eq($sformatf("u%0d.rst_wr_en", n), wen_v[n], 0);
            check_eq($sformatf("u%0d.rst_busy", n), busy_v[n], 0);
            check_eq($sformatf("u%0d.rst_done", n), done_v[n], 0);
        end
        @(negedge clk);
        @(negedge clk); #1;
        fill_req = '0;
        rst_v    = '0;
        @(negedge clk); #1;

        // Reference key with init, stray starts mid-run, then a back-to-back run without init.
        run_ksa(0, 1'b1, 256'h4B6579, 10, 2000);
        run_ksa(0, 1'b0, 256'hA1B2C3, -1, -1);

        // Reset mid-operation at cycle 1000, then a clean run with init.
        start_run(0, 1'b1, 256'h123456);
        rel = cyc - st_cyc[0];
        while (rel < 1000) begin
            @(negedge clk); #1;
            rel = cyc - st_cyc[0];
        end
        check_eq("u0.pre_reset_traffic", ev_bad[0] - eb0[0], 0);
        run_act[0] = 1'b0;
        rst_v[0]   = 1'b1;
        #1;
        check_eq("u0.async_rst_wr_en", wen_v[0], 0);
        check_eq("u0.async_rst_busy", busy_v[0], 0);
        check_eq("u0.async_rst_address", addr_v[0], 0);
        evq[0].delete();
        exp_s_q[0].delete();
        void'(exp_done_q[0].pop_front());
        repeat (3) @(negedge clk);
        #1;
        rst_v[0] = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check_eq("u0.no_done_after_reset", done_cnt[0] - d0[0], 0);
        run_ksa(0, 1'b1, 256'h4B6579, -1, -1);

        // Single zero key byte: iterations 0 and 1 hit the i==j case.
        run_ksa(1, 1'b1, 256'h00, -1, -1);

        // 32-byte key 0x00..0x1F on an identity-preloaded memory, no init phase.
        fill_req[2] = 1'b1;
        @(negedge clk); #1;
        fill_req[2] = 1'b0;
        key32 = '0;
        for (int k = 0; k < 32; k++) key32[8*(32-k)-1 -: 8] = 8'(k);
        run_ksa(2, 1'b0, key32, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
